// File: rtl/surface_ray_gen_mc.sv
// surface_ray_gen_mc -- multi-channel surface-ray generator.
//
// Rays from NUM_CH producers are queued in per-channel FIFOs. One ray at a
// time is granted (fixed priority or round-robin, ARB_MODE). Its inverse
// direction is computed by a single shared Fixed3_Inv_V3 unit, and the
// result is then presented downstream on a valid/ready handshake. A direction
// component of exactly zero yields +max Fixed as its inverse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   per-channel push handshake
//   in_data, in_dir     per-channel payload and {z,y,x} direction
//   out_valid/out_ready result handshake
//   out_data, out_dir   payload and direction of the result ray
//   out_inv_dir         guarded inverse direction {z,y,x}
//   out_ch              source channel of the result
// Optional (macro SURF_RAYGEN_STATS_EN): stat_rays, stat_stall counters.
//
// Fixed3_Inv_V3 -- component-wise reciprocal of a signed Fixed vector
// (FIX_W bits, FIX_W/2 fraction bits). It uses one restoring divider per
// component, one quotient bit per cycle, with truncation toward zero. A
// magnitude overflow saturates to +/-0x7FF..F. valid_o pulses once per
// strobe_i.

module Fixed3_Inv_V3 #(
  parameter int FIX_W = 32
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic               strobe_i,
  input  logic [3*FIX_W-1:0] dir_i,
  output logic               valid_o,
  output logic [3*FIX_W-1:0] inv_o
);
  localparam int FRAC = FIX_W / 2;
  localparam int CW   = $clog2(2 * FRAC + 1);

  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] cnt_q;
  logic          num_bit;

  // Dividend is 1.0 * 1.0 = 2^(2*FRAC). Only its bit 2*FRAC is set, so the
  // division walks the bits 2*FRAC down to 0.
  assign num_bit = (cnt_q == CW'(2 * FRAC));
  assign valid_o = done_q;

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (strobe_i) begin
        busy_q <= 1'b1;
        cnt_q  <= CW'(2 * FRAC);
      end else if (busy_q) begin
        if (cnt_q == '0) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_comp
    logic [FIX_W-1:0] x;
    logic [FIX_W-1:0] div_q;
    logic [FIX_W-1:0] rem_q;
    logic [FIX_W:0]   quo_q;
    logic [FIX_W:0]   rem_sh;
    logic             ge;
    logic             neg_q;
    logic [FIX_W-1:0] mag;

    assign x      = dir_i[gi*FIX_W +: FIX_W];
    assign rem_sh = {rem_q, num_bit};
    assign ge     = (rem_sh >= {1'b0, div_q});

    always_ff @(posedge clk) begin
      if (!resetn_i) begin
        div_q <= '0;
        rem_q <= '0;
        quo_q <= '0;
        neg_q <= 1'b0;
      end else if (strobe_i) begin
        div_q <= x[FIX_W-1] ? (~x + 1'b1) : x;
        neg_q <= x[FIX_W-1];
        rem_q <= '0;
        quo_q <= '0;
      end else if (busy_q) begin
        rem_q <= ge ? FIX_W'(rem_sh - {1'b0, div_q}) : rem_sh[FIX_W-1:0];
        quo_q <= {quo_q[FIX_W-1:0], ge};
      end
    end

    // Quotients that do not fit the positive signed range saturate.
    assign mag = (quo_q[FIX_W:FIX_W-1] != 2'b00) ? {1'b0, {(FIX_W-1){1'b1}}}
                                                 : quo_q[FIX_W-1:0];
    assign inv_o[gi*FIX_W +: FIX_W] = neg_q ? (~mag + 1'b1) : mag;
  end
endmodule

module surface_ray_gen_mc #(
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 256,
  parameter int FIX_W    = 32,
  parameter int ARB_MODE = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH*3*FIX_W-1:0]  in_dir,
`ifdef SURF_RAYGEN_STATS_EN
  output logic [31:0]                stat_rays,
  output logic [31:0]                stat_stall,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [3*FIX_W-1:0]         out_dir,
  output logic [3*FIX_W-1:0]         out_inv_dir,
  output logic [CH_W-1:0]            out_ch
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = DATA_W + 3 * FIX_W;

  typedef enum logic [1:0] {S_IDLE, S_INV_WAIT, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   nonempty;
  logic [NUM_CH-1:0]   pop;
  logic [EW-1:0]       head [NUM_CH];
  logic                grant_any, grant_en, latch_en, release_en;
  logic [CH_W-1:0]     grant_ch, idx_w, rr_last_q;
  int                  idx;
  logic [EW-1:0]       work_q;
  logic [CH_W-1:0]     work_ch_q;
  logic                strobe_q;
  logic                inv_valid;
  logic [3*FIX_W-1:0]  inv_res, inv_guard;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [3*FIX_W-1:0]  out_dir_q, out_inv_q;
  logic [CH_W-1:0]     out_ch_q;

  // Per-channel FIFOs. in_ready comes from the registered count only, so a
  // full FIFO refuses a push even on a cycle where it also pops.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push;

    assign in_ready[gi] = (count_q != (PW+1)'(DEPTH));
    assign push         = in_valid[gi] && in_ready[gi];
    assign nonempty[gi] = (count_q != '0);
    assign head[gi]     = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {in_data[gi*DATA_W +: DATA_W], in_dir[gi*3*FIX_W +: 3*FIX_W]};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop[gi]);
      end
    end
  end

  // Fixed priority searches from channel 0; round-robin starts after the
  // last granted channel.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx   = (ARB_MODE == 1) ? (int'(rr_last_q) + 1 + k) % NUM_CH : k;
      idx_w = CH_W'(idx);
      if (!grant_any && nonempty[idx_w]) begin
        grant_any = 1'b1;
        grant_ch  = idx_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (grant_any) state_d = S_INV_WAIT;
      S_INV_WAIT: if (inv_valid) state_d = S_HOLD;
      S_HOLD:     if (out_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_en   = (state_q == S_IDLE) && grant_any;
    latch_en   = (state_q == S_INV_WAIT) && inv_valid;
    release_en = (state_q == S_HOLD) && out_ready;
    pop        = '0;
    if (grant_en) pop[grant_ch] = 1'b1;
  end

  // The strobe is issued one cycle after the grant, so the unit samples the
  // work register rather than the FIFO head.
  Fixed3_Inv_V3 #(.FIX_W(FIX_W)) u_inv (
    .clk      (clk),
    .resetn_i (~reset),
    .strobe_i (strobe_q),
    .dir_i    (work_q[3*FIX_W-1:0]),
    .valid_o  (inv_valid),
    .inv_o    (inv_res)
  );

  always_comb begin
    inv_guard = inv_res;
    for (int k = 0; k < 3; k++) begin
      if (work_q[k*FIX_W +: FIX_W] == '0) inv_guard[k*FIX_W +: FIX_W] = {1'b0, {(FIX_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q      <= '0;
      work_ch_q   <= '0;
      strobe_q    <= 1'b0;
      rr_last_q   <= CH_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dir_q   <= '0;
      out_inv_q   <= '0;
      out_ch_q    <= '0;
    end else begin
      strobe_q <= grant_en;
      if (grant_en) begin
        work_q    <= head[grant_ch];
        work_ch_q <= grant_ch;
        rr_last_q <= grant_ch;
      end
      if (latch_en) begin
        out_valid_q <= 1'b1;
        out_data_q  <= work_q[EW-1 -: DATA_W];
        out_dir_q   <= work_q[3*FIX_W-1:0];
        out_inv_q   <= inv_guard;
        out_ch_q    <= work_ch_q;
      end else if (release_en) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_dir     = out_dir_q;
  assign out_inv_dir = out_inv_q;
  assign out_ch      = out_ch_q;

`ifdef SURF_RAYGEN_STATS_EN
  logic [31:0] stat_rays_q, stat_stall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rays_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (out_valid_q && out_ready && stat_rays_q != '1) stat_rays_q <= stat_rays_q + 1'b1;
      if (state_q == S_HOLD && !out_ready && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 1'b1;
    end
  end
  assign stat_rays  = stat_rays_q;
  assign stat_stall = stat_stall_q;
`endif
endmodule
